// File: rtl/hvac_pkg.sv
// hvac_pkg: shared types and helpers for the multi-zone HVAC controller.
// Optional build macro used by the zone FSM: HVAC_FAULT_LATCH_EN (sticky fault).
package hvac_pkg;

    typedef enum logic [2:0] {
        ZS_OFF   = 3'd0,
        ZS_IDLE  = 3'd1,
        ZS_HEAT  = 3'd2,
        ZS_COOL  = 3'd3,
        ZS_FAULT = 3'd4
    } zone_state_t;

    // Plant mode as chosen by the arbiter when no zone is already running
    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

    // Shared width of run and dead counters, large enough for either limit
    function automatic int cnt_width(input int min_run, input int dead);
        int mx;
        mx = (min_run > dead) ? min_run : dead;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/hvac_zone_fsm.sv
// hvac_zone_fsm: one zone's OFF/IDLE/HEAT/COOL/FAULT state machine with
// min-run and changeover dead-time counters. Entry into HEAT/COOL is gated by
// grants from the shared-plant arbiter in the top.
// Build macro: HVAC_FAULT_LATCH_EN makes FAULT sticky until fault_clr.
module hvac_zone_fsm
    import hvac_pkg::*;
#(
    parameter int MIN_RUN_CYC = 16,
    parameter int DEAD_CYC    = 8,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_power_on,
    input  logic        i_heat_req,
    input  logic        i_cool_req,
    input  logic        i_force_off,
    input  logic        i_fault_clr,
    input  logic        i_grant_heat,
    input  logic        i_grant_cool,
    output zone_state_t o_state,
    output logic        o_want_heat,
    output logic        o_want_cool
);

    localparam logic [CNT_W-1:0] MIN_RUN = CNT_W'(MIN_RUN_CYC);
    localparam logic [CNT_W-1:0] DEAD    = CNT_W'(DEAD_CYC);

    zone_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_run, w_run_nxt;
    logic [CNT_W-1:0] r_dead, w_dead_nxt;
    logic             w_pwr_ok, w_conflict, w_dead_done;

    assign w_pwr_ok    = i_power_on & ~i_force_off;
    assign w_conflict  = i_heat_req & i_cool_req;
    assign w_dead_done = (r_dead == '0);

    // A zone asks the arbiter only when it could actually enter a mode this cycle
    assign o_want_heat = (r_state == ZS_IDLE) & w_dead_done & w_pwr_ok & i_heat_req & ~i_cool_req;
    assign o_want_cool = (r_state == ZS_IDLE) & w_dead_done & w_pwr_ok & i_cool_req & ~i_heat_req;
    assign o_state     = r_state;

`ifndef HVAC_FAULT_LATCH_EN
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = i_fault_clr;
`endif

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ZS_OFF;
            r_run   <= '0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_dead  <= w_dead_nxt;
        end
    end

    // Next state: power/force-off first, then request conflict, then per-state rules
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_dead_nxt  = r_dead;
        if (!w_pwr_ok) begin
            w_state_nxt = ZS_OFF;
            w_run_nxt   = '0;
            w_dead_nxt  = '0;
        end else if (w_conflict && r_state != ZS_OFF) begin
            w_state_nxt = ZS_FAULT;
            w_run_nxt   = '0;
            w_dead_nxt  = '0;
        end else begin
            case (r_state)
                ZS_OFF: begin
                    w_state_nxt = ZS_IDLE;
                    w_run_nxt   = '0;
                    w_dead_nxt  = '0;
                end
                ZS_IDLE: begin
                    if (!w_dead_done) begin
                        w_dead_nxt = r_dead - 1'b1;
                    end else if (i_heat_req && i_grant_heat) begin
                        w_state_nxt = ZS_HEAT;
                        w_run_nxt   = '0;
                    end else if (i_cool_req && i_grant_cool) begin
                        w_state_nxt = ZS_COOL;
                        w_run_nxt   = '0;
                    end
                end
                ZS_HEAT: begin
                    if (!i_heat_req && r_run >= MIN_RUN) begin
                        w_state_nxt = ZS_IDLE;
                        w_run_nxt   = '0;
                        w_dead_nxt  = DEAD;
                    end else if (r_run < MIN_RUN) begin
                        w_run_nxt = r_run + 1'b1;
                    end
                end
                ZS_COOL: begin
                    if (!i_cool_req && r_run >= MIN_RUN) begin
                        w_state_nxt = ZS_IDLE;
                        w_run_nxt   = '0;
                        w_dead_nxt  = DEAD;
                    end else if (r_run < MIN_RUN) begin
                        w_run_nxt = r_run + 1'b1;
                    end
                end
                ZS_FAULT: begin
`ifdef HVAC_FAULT_LATCH_EN
                    if (i_fault_clr) begin
                        w_state_nxt = ZS_IDLE;
                        w_dead_nxt  = DEAD;
                    end
`else
                    w_state_nxt = ZS_IDLE;
                    w_dead_nxt  = '0;
`endif
                end
                default: begin
                    w_state_nxt = ZS_OFF;
                    w_run_nxt   = '0;
                    w_dead_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: NUM_ZONES zone FSMs sharing one heat/cool plant. Holds the
// heat/cool grant arbiter and the plant/fault OR-reductions.
// Build macro: HVAC_FAULT_LATCH_EN (sticky per-zone fault, cleared by fault_clr).
module hvac_zone_ctrl
    import hvac_pkg::*;
#(
    parameter int NUM_ZONES   = 4,
    parameter int MIN_RUN_CYC = 16,
    parameter int DEAD_CYC    = 8,
    parameter bit ALLOW_MIXED = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_ZONES-1:0] power_on,
    input  logic [NUM_ZONES-1:0] heat_req,
    input  logic [NUM_ZONES-1:0] cool_req,
    input  logic [NUM_ZONES-1:0] force_off,
    input  logic [NUM_ZONES-1:0] fault_clr,
    output logic [NUM_ZONES-1:0] off_o,
    output logic [NUM_ZONES-1:0] idle_o,
    output logic [NUM_ZONES-1:0] heat_o,
    output logic [NUM_ZONES-1:0] cool_o,
    output logic [NUM_ZONES-1:0] fault_o,
    output logic                 plant_heat,
    output logic                 plant_cool,
    output logic                 fault_any
);

    localparam int CNT_W = cnt_width(MIN_RUN_CYC, DEAD_CYC);

    zone_state_t          w_state [NUM_ZONES];
    logic [NUM_ZONES-1:0] w_want_heat, w_want_cool;
    logic                 w_heat_act, w_cool_act, w_first_found, w_first_mode;
    logic                 w_grant_heat, w_grant_cool;

    // Plant arbitration: a running mode blocks the opposite one; with nothing
    // running, the lowest-index zone ready to enter picks the mode
    always_comb begin
        w_heat_act    = 1'b0;
        w_cool_act    = 1'b0;
        w_first_found = 1'b0;
        w_first_mode  = MODE_HEAT;
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (w_state[i] == ZS_HEAT) w_heat_act = 1'b1;
            if (w_state[i] == ZS_COOL) w_cool_act = 1'b1;
            if (!w_first_found && (w_want_heat[i] || w_want_cool[i])) begin
                w_first_found = 1'b1;
                w_first_mode  = w_want_cool[i] ? MODE_COOL : MODE_HEAT;
            end
        end
        if (ALLOW_MIXED) begin
            w_grant_heat = 1'b1;
            w_grant_cool = 1'b1;
        end else begin
            w_grant_heat = !w_cool_act &&
                           (w_heat_act || !w_first_found || w_first_mode == MODE_HEAT);
            w_grant_cool = !w_heat_act &&
                           (w_cool_act || !w_first_found || w_first_mode == MODE_COOL);
        end
    end

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
        hvac_zone_fsm #(
            .MIN_RUN_CYC (MIN_RUN_CYC),
            .DEAD_CYC    (DEAD_CYC),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_power_on   (power_on[g]),
            .i_heat_req   (heat_req[g]),
            .i_cool_req   (cool_req[g]),
            .i_force_off  (force_off[g]),
            .i_fault_clr  (fault_clr[g]),
            .i_grant_heat (w_grant_heat),
            .i_grant_cool (w_grant_cool),
            .o_state      (w_state[g]),
            .o_want_heat  (w_want_heat[g]),
            .o_want_cool  (w_want_cool[g])
        );

        assign off_o[g]   = (w_state[g] == ZS_OFF);
        assign idle_o[g]  = (w_state[g] == ZS_IDLE);
        assign heat_o[g]  = (w_state[g] == ZS_HEAT);
        assign cool_o[g]  = (w_state[g] == ZS_COOL);
        assign fault_o[g] = (w_state[g] == ZS_FAULT);
    end

    assign plant_heat = |heat_o;
    assign plant_cool = |cool_o;
    assign fault_any  = |fault_o;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// tb_hvac_zone_ctrl: directed scenarios followed by randomized traffic, all
// checked against a zone-level behavioural model kept in the bench.
module tb_hvac_zone_ctrl;

    localparam int NZ = 4;
    localparam int MR = 16;
    localparam int DC = 8;

    localparam int S_OFF = 0, S_IDLE = 1, S_HEAT = 2, S_COOL = 3, S_FAULT = 4;
    localparam int M_NONE = 0, M_HEAT = 1, M_COOL = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NZ-1:0] power_on, heat_req, cool_req, force_off, fault_clr;
    logic [NZ-1:0] off_o, idle_o, heat_o, cool_o, fault_o;
    logic          plant_heat, plant_cool, fault_any;

    int n_asrt = 0;
    int n_fail = 0;
    int ms [NZ];
    int mrun [NZ];
    int mdead [NZ];

    hvac_zone_ctrl #(
        .NUM_ZONES   (NZ),
        .MIN_RUN_CYC (MR),
        .DEAD_CYC    (DC),
        .ALLOW_MIXED (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .power_on   (power_on),
        .heat_req   (heat_req),
        .cool_req   (cool_req),
        .force_off  (force_off),
        .fault_clr  (fault_clr),
        .off_o      (off_o),
        .idle_o     (idle_o),
        .heat_o     (heat_o),
        .cool_o     (cool_o),
        .fault_o    (fault_o),
        .plant_heat (plant_heat),
        .plant_cool (plant_cool),
        .fault_any  (fault_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NZ; i++) begin
            ms[i] = S_OFF; mrun[i] = 0; mdead[i] = 0;
        end
    endfunction

    // One clock of the whole controller, from the current inputs
    function automatic void model_step();
        int ns [NZ];
        int nr [NZ];
        int nd [NZ];
        int mode = M_NONE;
        bit pwr;
        for (int i = 0; i < NZ; i++) begin
            if (ms[i] == S_HEAT) mode = M_HEAT;
            if (ms[i] == S_COOL) mode = M_COOL;
        end
        if (mode == M_NONE) begin
            for (int i = NZ - 1; i >= 0; i--) begin
                if (ms[i] == S_IDLE && mdead[i] == 0 && power_on[i] && !force_off[i] &&
                    heat_req[i] != cool_req[i])
                    mode = heat_req[i] ? M_HEAT : M_COOL;
            end
        end
        for (int i = 0; i < NZ; i++) begin
            ns[i] = ms[i]; nr[i] = mrun[i]; nd[i] = mdead[i];
            pwr = power_on[i] && !force_off[i];
            if (!pwr) begin
                ns[i] = S_OFF; nr[i] = 0; nd[i] = 0;
            end else if (heat_req[i] && cool_req[i] && ms[i] != S_OFF) begin
                ns[i] = S_FAULT; nr[i] = 0; nd[i] = 0;
            end else if (ms[i] == S_OFF) begin
                ns[i] = S_IDLE; nr[i] = 0; nd[i] = 0;
            end else if (ms[i] == S_IDLE) begin
                if (mdead[i] > 0) nd[i] = mdead[i] - 1;
                else if (heat_req[i] && mode != M_COOL) begin ns[i] = S_HEAT; nr[i] = 0; end
                else if (cool_req[i] && mode != M_HEAT) begin ns[i] = S_COOL; nr[i] = 0; end
            end else if (ms[i] == S_HEAT || ms[i] == S_COOL) begin
                if (!(ms[i] == S_HEAT ? heat_req[i] : cool_req[i]) && mrun[i] >= MR) begin
                    ns[i] = S_IDLE; nr[i] = 0; nd[i] = DC;
                end else begin
                    nr[i] = (mrun[i] + 1 > MR) ? MR : mrun[i] + 1;
                end
            end else begin
`ifdef HVAC_FAULT_LATCH_EN
                if (fault_clr[i]) begin ns[i] = S_IDLE; nd[i] = DC; end
`else
                ns[i] = S_IDLE; nd[i] = 0;
`endif
            end
        end
        for (int i = 0; i < NZ; i++) begin
            ms[i] = ns[i]; mrun[i] = nr[i]; mdead[i] = nd[i];
        end
    endfunction

    task automatic compare_model();
        logic [NZ-1:0] eo, ei, eh, ec, ef;
        eo = '0; ei = '0; eh = '0; ec = '0; ef = '0;
        for (int i = 0; i < NZ; i++) begin
            eo[i] = (ms[i] == S_OFF);
            ei[i] = (ms[i] == S_IDLE);
            eh[i] = (ms[i] == S_HEAT);
            ec[i] = (ms[i] == S_COOL);
            ef[i] = (ms[i] == S_FAULT);
        end
        chk("off_o", off_o, eo);
        chk("idle_o", idle_o, ei);
        chk("heat_o", heat_o, eh);
        chk("cool_o", cool_o, ec);
        chk("fault_o", fault_o, ef);
        chk("plant_heat", plant_heat, |eh);
        chk("plant_cool", plant_cool, |ec);
        chk("fault_any", fault_any, |ef);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        power_on = '0; heat_req = '0; cool_req = '0; force_off = '0; fault_clr = '0;
        model_reset();
        @(negedge clk);
        compare_model();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pat;
        do_reset();
        chk("rst_off", off_o, 4'hF);
        chk("rst_heat", heat_o, 4'h0);
        chk("rst_plant", {plant_heat, plant_cool, fault_any}, 3'b000);

        // power-up and heat entry
        power_on = 4'b0001; tick();
        chk("t1_idle0", idle_o[0], 1'b1);
        heat_req[0] = 1'b1; tick();
        chk("t1_heat0", heat_o[0], 1'b1);
        chk("t1_plant_heat", plant_heat, 1'b1);

        // min-run hold, then changeover dead time
        repeat (3) tick();
        heat_req[0] = 1'b0;
        n = 0;
        while (!idle_o[0] && n < 40) begin tick(); n++; end
        chk("t2_minrun_cycles", n, 14);
        cool_req[0] = 1'b1;
        n = 0;
        while (!cool_o[0] && n < 40) begin tick(); n++; end
        chk("t2_dead_cycles", n, 9);

        // zone 1 conflicting requests
        power_on[1] = 1'b1; tick();
        heat_req[1] = 1'b1; cool_req[1] = 1'b1; tick();
        chk("t3_fault1", fault_o[1], 1'b1);
        chk("t3_fault_any", fault_any, 1'b1);
        heat_req[1] = 1'b0; cool_req[1] = 1'b0; tick();
`ifdef HVAC_FAULT_LATCH_EN
        chk("t3_fault_sticky", fault_o[1], 1'b1);
        tick();
        chk("t3_fault_sticky2", fault_o[1], 1'b1);
        fault_clr[1] = 1'b1; tick();
        chk("t3_fault_cleared", idle_o[1], 1'b1);
        fault_clr[1] = 1'b0;
`else
        chk("t3_fault_release", idle_o[1], 1'b1);
`endif

        // same-cycle opposing entries
        do_reset();
        power_on = 4'hF; tick();
        heat_req[2] = 1'b1; cool_req[3] = 1'b1; tick();
        chk("t4_heat2", heat_o[2], 1'b1);
        chk("t4_idle3", idle_o[3], 1'b1);
        repeat (5) tick();
        chk("t4_idle3_held", idle_o[3], 1'b1);
        heat_req[2] = 1'b0;
        n = 0;
        while (!idle_o[2] && n < 40) begin tick(); n++; end
        chk("t4_z2_release", idle_o[2], 1'b1);
        chk("t4_z3_blocked", cool_o[3], 1'b0);
        tick();
        chk("t4_z3_cool", cool_o[3], 1'b1);

        // force_off and async reset mid min-run
        do_reset();
        power_on[0] = 1'b1; tick();
        heat_req[0] = 1'b1; repeat (3) tick();
        force_off[0] = 1'b1; tick();
        chk("t5_force_off", off_o[0], 1'b1);
        chk("t5_force_heat", heat_o[0], 1'b0);
        force_off[0] = 1'b0; tick();
        chk("t5_repower_idle", idle_o[0], 1'b1);
        tick();
        chk("t5_reheat", heat_o[0], 1'b1);
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_off", off_o, 4'hF);
        chk("t5_async_heat", heat_o[0], 1'b0);
        chk("t5_async_plant", plant_heat, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic with sticky per-zone request patterns
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NZ; i++) begin
                if ($urandom_range(63) == 0) power_on[i] = ~power_on[i];
                else if (!power_on[i] && $urandom_range(3) == 0) power_on[i] = 1'b1;
                force_off[i] = ($urandom_range(99) < 2);
                fault_clr[i] = ($urandom_range(3) == 0);
                if ($urandom_range(7) == 0) begin
                    pat = $urandom_range(99);
                    heat_req[i] = (pat >= 35 && pat < 65) || pat >= 95;
                    cool_req[i] = (pat >= 65);
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
